// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: requester-side and ALU-side bundle for the round-robin ALU scheduler
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WIDTH-1:0]     req_opa;
  logic [NUM_REQ*WIDTH-1:0]     req_opb;
  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [NUM_REQ-1:0]           req_mode;
  logic [NUM_REQ-1:0]           req_cin;
  logic [NUM_REQ*2-1:0]         req_inp_valid;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [2*WIDTH-1:0]           rsp_res;
  logic [5:0]                   rsp_flags;
  logic                         busy;
  logic [WIDTH-1:0]             alu_opa;
  logic [WIDTH-1:0]             alu_opb;
  logic [CMD_WIDTH-1:0]         alu_cmd;
  logic                         alu_mode;
  logic                         alu_cin;
  logic                         alu_ce;
  logic [1:0]                   alu_inp_valid;
  logic [2*WIDTH-1:0]           alu_res;
  logic [5:0]                   alu_flags;
  modport sched (
    input  req, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, alu_res, alu_flags,
    output gnt, rsp_valid, rsp_res, rsp_flags, busy,
           alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid
  );
  modport master (
    output req, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, alu_res, alu_flags,
    input  gnt, rsp_valid, rsp_res, rsp_flags, busy,
           alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one ALU among NUM_REQ requesters, one operation in flight
module alu_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  alu_rr_scheduler_if.sched bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t               r_state, w_next;
  logic [PW-1:0]        r_ptr, r_owner, w_sel;
  logic                 w_any, w_act;
  int                   w_idx;
  logic [WIDTH-1:0]     r_opa, r_opb;
  logic [CMD_WIDTH-1:0] r_cmd;
  logic                 r_mode, r_cin;
  logic [1:0]           r_iv;
  logic [7:0]           r_cnt;
  logic [2*WIDTH-1:0]   r_res;
  logic [5:0]           r_flags;
  // first requester at or after the pointer, wrapping
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    w_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_any && bus.req[w_idx]) begin
        w_any = 1'b1;
        w_sel = PW'(w_idx);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (r_cnt == 8'd1) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_cmd   <= '0;
      r_mode  <= 1'b0;
      r_cin   <= 1'b0;
      r_iv    <= 2'b00;
      r_cnt   <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_sel;
        r_ptr   <= (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
        r_opa   <= bus.req_opa[w_sel*WIDTH +: WIDTH];
        r_opb   <= bus.req_opb[w_sel*WIDTH +: WIDTH];
        r_cmd   <= bus.req_cmd[w_sel*CMD_WIDTH +: CMD_WIDTH];
        r_mode  <= bus.req_mode[w_sel];
        r_cin   <= bus.req_cin[w_sel];
        r_iv    <= bus.req_inp_valid[w_sel*2 +: 2];
      end
      if (r_state == ISSUE)
        r_cnt <= (r_mode && (r_cmd == CMD_WIDTH'(9) || r_cmd == CMD_WIDTH'(10))) ? 8'(MUL_LAT) : 8'(ALU_LAT);
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          r_res   <= bus.alu_res;
          r_flags <= bus.alu_flags;
        end
      end
    end
  end
  assign w_act             = (r_state == ISSUE) || (r_state == WAIT);
  assign bus.gnt           = (i_rst_n && r_state == IDLE && w_any) ? NUM_REQ'(1) << w_sel : '0;
  assign bus.rsp_valid     = (r_state == RESP) ? NUM_REQ'(1) << r_owner : '0;
  assign bus.rsp_res       = r_res;
  assign bus.rsp_flags     = r_flags;
  assign bus.busy          = r_state != IDLE;
  assign bus.alu_ce        = w_act;
  assign bus.alu_opa       = w_act ? r_opa : '0;
  assign bus.alu_opb       = w_act ? r_opb : '0;
  assign bus.alu_cmd       = w_act ? r_cmd : '0;
  assign bus.alu_mode      = w_act && r_mode;
  assign bus.alu_cin       = w_act && r_cin;
  assign bus.alu_inp_valid = w_act ? r_iv : 2'b00;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed checks of arbitration order, latency, capture and reset abort
module tb_alu_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [15:0] stub_val;
  logic [5:0]  stub_flags;
  int          stub_lat;
  int          stub_cnt = 0;

  alu_rr_scheduler_if #(.NUM_REQ(4), .WIDTH(8), .CMD_WIDTH(4)) bus ();

  alu_rr_scheduler #(.NUM_REQ(4), .WIDTH(8), .CMD_WIDTH(4), .ALU_LAT(1), .MUL_LAT(2)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ALU stub: result becomes valid only after CE has been high for stub_lat cycles
  always @(posedge clk) stub_cnt <= bus.alu_ce ? stub_cnt + 1 : 0;
  assign bus.alu_res   = (stub_cnt >= stub_lat) ? stub_val : 16'hdead;
  assign bus.alu_flags = (stub_cnt >= stub_lat) ? stub_flags : 6'h3e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] cmd,
                         input logic mode, input logic cin, input logic [1:0] iv);
    bus.req_opa[i*8 +: 8]       = opa;
    bus.req_opb[i*8 +: 8]       = opb;
    bus.req_cmd[i*4 +: 4]       = cmd;
    bus.req_mode[i]             = mode;
    bus.req_cin[i]              = cin;
    bus.req_inp_valid[i*2 +: 2] = iv;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.req_opa = '0; bus.req_opb = '0; bus.req_cmd = '0;
    bus.req_mode = '0; bus.req_cin = '0; bus.req_inp_valid = '0;
    stub_val = '0; stub_flags = '0; stub_lat = 1;
    repeat (2) @(negedge clk);
    bus.req = 4'b0100;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ce", bus.alu_ce, 0);
    chk("rst_rspv", bus.rsp_valid, 0);
    chk("rst_res", bus.rsp_res, 0);
    chk("rst_flags", bus.rsp_flags, 0);
    chk("rst_opa", bus.alu_opa, 0);
    chk("rst_iv", bus.alu_inp_valid, 0);
    bus.req = '0;
    @(negedge clk); rst_n = 1'b1;
    // single request, ordinary latency
    @(negedge clk);
    set_req(2, 8'd10, 8'd5, 4'd0, 1'b1, 1'b0, 2'b11);
    stub_val = 16'd15; stub_lat = 1;
    bus.req = 4'b0100;
    #1 chk("t1_gnt", bus.gnt, 4'b0100);
    @(negedge clk); bus.req = '0;
    #1;
    chk("t1_ce1", bus.alu_ce, 1);
    chk("t1_opa", bus.alu_opa, 10);
    chk("t1_opb", bus.alu_opb, 5);
    chk("t1_mode", bus.alu_mode, 1);
    chk("t1_iv", bus.alu_inp_valid, 2'b11);
    chk("t1_busy", bus.busy, 1);
    chk("t1_gnt0", bus.gnt, 0);
    @(negedge clk);
    #1;
    chk("t1_ce2", bus.alu_ce, 1);
    chk("t1_rspv_early", bus.rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("t1_rspv", bus.rsp_valid, 4'b0100);
    chk("t1_res", bus.rsp_res, 15);
    chk("t1_ce_resp", bus.alu_ce, 0);
    chk("t1_iv_resp", bus.alu_inp_valid, 0);
    @(negedge clk);
    #1;
    chk("t1_rspv_off", bus.rsp_valid, 0);
    chk("t1_idle", bus.busy, 0);
    chk("t1_res_hold", bus.rsp_res, 15);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    // all four requesting: rotation 0,1,2,3,0 at 4-cycle spacing
    for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd1, 4'd0, 1'b0, 1'b0, 2'b11);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      stub_val = 16'(g * 3 + 1);
      #1 chk($sformatf("t2_gnt%0d", g), bus.gnt, 32'(4'b0001 << (g % 4)));
      repeat (3) @(negedge clk);
      if (g == 4) bus.req = '0;
      #1;
      chk($sformatf("t2_rspv%0d", g), bus.rsp_valid, 32'(4'b0001 << (g % 4)));
      chk($sformatf("t2_res%0d", g), bus.rsp_res, 32'(g * 3 + 1));
      @(negedge clk);
    end
    // multiply command takes the longer latency
    set_req(1, 8'd3, 8'd4, 4'd9, 1'b1, 1'b0, 2'b11);
    stub_val = 16'h0014; stub_lat = 2;
    bus.req = 4'b0010;
    #1 chk("t3_gnt", bus.gnt, 4'b0010);
    @(negedge clk); bus.req = '0;
    #1;
    chk("t3_ce", bus.alu_ce, 1);
    chk("t3_cmd", bus.alu_cmd, 9);
    chk("t3_opa", bus.alu_opa, 3);
    @(negedge clk);
    #1 chk("t3_rspv_t2", bus.rsp_valid, 0);
    @(negedge clk);
    #1 chk("t3_rspv_t3", bus.rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("t3_rspv", bus.rsp_valid, 4'b0010);
    chk("t3_res", bus.rsp_res, 16'h0014);
    @(negedge clk);
    // pointer at 2 after granting 1: with bits 0 and 1 pending, 0 wins
    set_req(0, 8'd7, 8'd1, 4'd0, 1'b0, 1'b0, 2'b11);
    stub_val = 16'h0077; stub_lat = 1;
    bus.req = 4'b0011;
    #1 chk("t4_gnt", bus.gnt, 4'b0001);
    @(negedge clk); bus.req = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("t4_rspv", bus.rsp_valid, 4'b0001);
    chk("t4_res", bus.rsp_res, 16'h0077);
    @(negedge clk);
    // reset while waiting on the ALU
    set_req(3, 8'h55, 8'h22, 4'd1, 1'b0, 1'b0, 2'b11);
    stub_val = 16'h0055;
    bus.req = 4'b1000;
    #1 chk("t5_gnt", bus.gnt, 4'b1000);
    @(negedge clk); bus.req = '0;
    @(negedge clk);
    #1 chk("t5_wait_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_ce", bus.alu_ce, 0);
    chk("t5_opa", bus.alu_opa, 0);
    chk("t5_rspv", bus.rsp_valid, 0);
    chk("t5_res", bus.rsp_res, 0);
    @(negedge clk);
    #1 chk("t5_no_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    bus.req = 4'b1000;
    #1 chk("t5_regnt", bus.gnt, 4'b1000);
    @(negedge clk); bus.req = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_rspv2", bus.rsp_valid, 4'b1000);
    chk("t5_res2", bus.rsp_res, 16'h0055);
    @(negedge clk);
    // ALU error flag returned verbatim
    set_req(0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 2'b00);
    stub_val = 16'h0000; stub_flags = 6'b000001;
    bus.req = 4'b0001;
    #1 chk("t6_gnt", bus.gnt, 4'b0001);
    @(negedge clk); bus.req = '0;
    #1;
    chk("t6_ce", bus.alu_ce, 1);
    chk("t6_iv", bus.alu_inp_valid, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    chk("t6_rspv", bus.rsp_valid, 4'b0001);
    chk("t6_flags", bus.rsp_flags, 6'b000001);
    chk("t6_res", bus.rsp_res, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
